// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian words into the
// instruction memory from address 0, and releases the CPU only after the checksum matches.
module imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4096,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {IDLE, SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Idle counter only has to reach TIMEOUT-1; the expiry fires on the following idle cycle.
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q;
  logic                rx_ready_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                cpu_rst_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          err_q;
  logic [23:0]         word_q;
  logic [7:0]          csum_q;
  logic [7:0]          len_hi_q;
  logic [15:0]         count_q;
  logic [1:0]          byte_idx_q;
  logic [TO_W-1:0]     to_cnt_q;

  logic        accept;
  logic [15:0] len_d;
  logic        len_bad;
  logic        timed;
  logic        last_word;
  logic        timeout_hit;

  assign accept      = rx_valid && rx_ready_q;
  assign len_d       = {len_hi_q, rx_data};
  assign len_bad     = (len_d == 16'd0) || (int'({16'd0, len_d}) > DEPTH);
  assign timed       = state_q inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign last_word   = (17'(waddr_q) + 17'd1) == {1'b0, count_q};
  assign timeout_hit = (TIMEOUT != 0) && timed && !accept && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
      word_q     <= '0;
      csum_q     <= '0;
      len_hi_q   <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      if (!timed || accept) to_cnt_q <= '0;
      else if (to_cnt_q != TO_LAST) to_cnt_q <= to_cnt_q + 1'b1;

      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q    <= SYNC;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            waddr_q    <= '0;
            csum_q     <= '0;
            rx_ready_q <= 1'b1;
          end
        end
        SYNC: begin
          // Anything other than the sync byte is dropped while hunting.
          if (accept && rx_data == SYNC_BYTE) state_q <= LEN_HI;
        end
        LEN_HI: begin
          if (accept) begin
            len_hi_q <= rx_data;
            state_q  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            if (len_bad) begin
              state_q    <= ERR;
              err_q      <= ERR_LEN;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b0;
            end else begin
              count_q    <= len_d;
              byte_idx_q <= '0;
              state_q    <= DATA;
            end
          end
        end
        DATA: begin
          if (we_q) begin
            we_q       <= 1'b0;
            rx_ready_q <= 1'b1;
            if (last_word) state_q <= CSUM;
            else           waddr_q <= waddr_q + 1'b1;
          end else if (accept) begin
            word_q     <= {word_q[15:0], rx_data};
            csum_q     <= csum_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              wdata_q    <= {word_q, rx_data};
              rx_ready_q <= 1'b0;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (rx_data == csum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= ERR_CSUM;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: the last non-blocking assignment to a register wins, so this
      // expiry overrides whatever the state case scheduled above.
      if (timeout_hit) begin
        state_q    <= ERR;
        err_q      <= ERR_TIMEOUT;
        busy_q     <= 1'b0;
        rx_ready_q <= 1'b0;
        we_q       <= 1'b0;
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
